iic_oled_burst_wr: RTL and testbench
====================================

# iic_oled_burst_wr

Second-generation I2C write master for the OLED path. It runs entirely in the sys_clk domain using a quarter-bit tick enable rather than a derived clock. One transaction sends START, the address byte, a control byte (0x00 command / 0x40 data) and a burst of 1..2^LEN_W payload bytes streamed over a valid/ready port, then STOP. Every byte's ACK is checked, and a NACK aborts the frame with an error flag.

## Interface
- SYS_CLK, 50_000_000: system clock frequency in Hz.
- IIC_CLK, 400_000: SCL frequency in Hz.
- SLAVE_ADDR, 7'b0111100: 7-bit slave address; the R/W bit is always 0.
- LEN_W, 8: width of cmd_len; the maximum burst is 2^LEN_W bytes.
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  transaction request.
- cmd_ready  out  1  high while IDLE; a transaction is accepted when cmd_valid and cmd_ready are both high.
- cmd_ctrl  in  1  1 selects command (control byte 0x00); 0 selects data (control byte 0x40).
- cmd_len  in  LEN_W  payload byte count minus one.
- wr_valid  in  1  payload byte available.
- wr_ready  out  1  payload byte consumed when wr_valid and wr_ready are both high.
- wr_data  in  8  payload byte, sent MSB first.
- iic_scl  out  1  SCL, push-pull.
- iic_sda_oe  out  1  1 pulls SDA low; 0 releases SDA (open-drain).
- iic_sda_i  in  1  SDA pin sense, used only for ACK sampling.
- busy  out  1  high from accept until the end of STOP.
- done  out  1  one-cycle pulse at the end of the frame.
- nack  out  1  qualifies done: 1 means the frame was aborted by a NACK.

## Operation
- DIV = SYS_CLK/(IIC_CLK*4), integer division. DIV must be at least 2; elaborate-time check.
- The tick is a one-cycle pulse every DIV sys_clk cycles.
- The tick counter is held at 0 in IDLE and restarts on accept.
- All bus activity advances only on tick.
- States: IDLE, START, ADDR, CTRL, DATA, STOP.
- IDLE:
  - SCL=1, sda_oe=0.
  - On accept, latch cmd_ctrl and cmd_len into byte_cnt, then go to START.
- START, 2 quarters:
  - q0: sda_oe=1 with SCL high.
  - q1: SCL=0.
- Byte phase, 9 bits × 4 quarters:
  - q0: SCL low, drive the bit (sda_oe = ~bit).
  - q1: SCL=1.
  - q2: SCL=1.
  - q3: SCL=0.
- Bit 9 is the ACK bit: sda_oe=0, and iic_sda_i is sampled on the q2 tick.
  - Sample 1 means NACK: go to STOP with the nack flag set.
- Byte sequence:
  - ADDR sends {SLAVE_ADDR,1'b0}.
  - CTRL sends the latched control byte.
  - DATA sends payload bytes.
- After each ACKed DATA byte: if byte_cnt == 0, go to STOP; otherwise decrement byte_cnt and send the next byte.
- Payload fetch:
  - Before each DATA byte, wr_ready is asserted at q0 of bit 1.
  - If wr_valid is high, the byte is loaded into the shifter.
  - If wr_valid is low, wr_ready stays high, the tick counter freezes and SCL stays low until wr_valid arrives (master stretch).
- STOP, 3 quarters:
  - q0: SCL low, sda_oe=1.
  - q1: SCL=1.
  - q2: sda_oe=0.
  - On the next cycle: done=1, nack=flag, busy=0, then IDLE.
- nack holds its value until the next accept.
- cmd_valid while busy is ignored; nothing is queued.
- Reset mid-frame:
  - All outputs take their reset values asynchronously and the FSM returns to IDLE.
  - No STOP is generated; the bus is released.

## Timing
- Reset values:
  - iic_scl=1, iic_sda_oe=0.
  - cmd_ready=1, wr_ready=0.
  - busy=0, done=0, nack=0.
- Accept to START first tick: DIV cycles.
- Frame length, unstretched, ACKed:
  - (2 + 36×(2+N) + 3) ticks, plus 1 cycle for done.
  - N = cmd_len+1.
- cmd_ready drops the cycle after accept and rises with done.
- wr_ready deasserts the cycle after handshake; there is at most one handshake per byte.
- A NACK on ADDR or CTRL means wr_ready is never asserted.
- A NACK on DATA k means exactly k bytes are consumed.
- SDA changes only while SCL is low, except at START and STOP.

## Structure
- Package iic_pkg holds:
  - the state enum;
  - CTRL_CMD=8'h00 and CTRL_DATA=8'h40;
  - the quarter index type.
- Sub-module iic_tick_gen: the DIV counter with clear and freeze inputs and a tick output.
- Top level: the FSM, the 8-bit shifter, the 4-bit bit counter, the 2-bit quarter counter and the LEN_W byte counter.

## Test plan
- Command byte 0xAE, all ACKs:
  - The SDA decode reads 0x78, 0x00, 0xAE, then STOP.
  - done pulses with nack=0.
  - Frame length is 2+108+3 ticks.
- Data burst, cmd_len=2, bytes 0x11, 0x22, 0x33:
  - The bus reads 0x78, 0x40, 0x11, 0x22, 0x33.
  - There are exactly 3 wr handshakes.
- Slave holds SDA high on the address ACK:
  - STOP follows immediately and done pulses with nack=1.
  - wr_ready is never asserted.
- wr_valid withheld for 100 cycles before byte 2:
  - SCL stays low and sda_oe is stable throughout.
  - The frame resumes correctly, and the total frame length grows by the stall.
- Reset asserted mid-CTRL:
  - Reset values appear immediately and cmd_ready=1.
  - A following command frame completes normally.
- cmd_valid pulsed while busy is ignored.
- Back-to-back commands accepted the cycle after done both complete.
- Run with LEN_W=1 and cmd_len=1: 2 payload bytes are sent.

Source files
------------

// File: rtl/iic_pkg.sv
// Shared types and constants for the OLED I2C burst write master.
package iic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    CTRL,
    DATA,
    STOP
  } iic_state_t;

  localparam logic [7:0] CTRL_CMD  = 8'h00;
  localparam logic [7:0] CTRL_DATA = 8'h40;

  typedef logic [1:0] quarter_t;

endpackage

// File: rtl/iic_tick_gen.sv
// Quarter-bit tick enable: one-cycle pulse every DIV sys_clk cycles.
module iic_tick_gen #(
  parameter int DIV = 31
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic clear,
  input  logic freeze,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // Freeze holds the phase so a master stretch simply lengthens the current quarter
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (!freeze) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clear && !freeze;

endmodule

// File: rtl/iic_oled_burst_wr.sv
// I2C write master: START, address, control byte, 1..2^LEN_W payload bytes, STOP.
module iic_oled_burst_wr
  import iic_pkg::*;
#(
  parameter int         SYS_CLK    = 50_000_000,
  parameter int         IIC_CLK    = 400_000,
  parameter logic [6:0] SLAVE_ADDR = 7'b0111100,
  parameter int         LEN_W      = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_ctrl,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             iic_scl,
  output logic             iic_sda_oe,
  input  logic             iic_sda_i,
  output logic             busy,
  output logic             done,
  output logic             nack
);

  localparam int DIV = SYS_CLK / (IIC_CLK * 4);
  localparam logic [3:0] ACK_BIT = 4'd8;

  generate
    if (DIV < 2) begin : g_div_check
      $error("iic_oled_burst_wr: SYS_CLK/(IIC_CLK*4) must be at least 2");
    end
  endgenerate

  iic_state_t       state;
  quarter_t         quarter;
  logic [3:0]       bit_cnt;
  logic [7:0]       shifter;
  logic [7:0]       ctrl_byte;
  logic [LEN_W-1:0] byte_cnt;
  logic             nack_flag;
  logic             tick;

  iic_tick_gen #(.DIV(DIV)) u_tick (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .clear     (state == IDLE),
    .freeze    (wr_ready && !wr_valid),
    .tick      (tick)
  );

  // Each tick performs the action of the current quarter and then advances;
  // the payload handshake always lands before the q0 tick of a DATA byte.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= IDLE;
      quarter    <= '0;
      bit_cnt    <= '0;
      shifter    <= '0;
      ctrl_byte  <= CTRL_CMD;
      byte_cnt   <= '0;
      nack_flag  <= 1'b0;
      iic_scl    <= 1'b1;
      iic_sda_oe <= 1'b0;
      cmd_ready  <= 1'b1;
      wr_ready   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      nack       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wr_ready && wr_valid) begin
        shifter  <= wr_data;
        wr_ready <= 1'b0;
      end
      case (state)
        IDLE: begin
          iic_scl    <= 1'b1;
          iic_sda_oe <= 1'b0;
          quarter    <= '0;
          bit_cnt    <= '0;
          if (cmd_valid && cmd_ready) begin
            ctrl_byte <= cmd_ctrl ? CTRL_CMD : CTRL_DATA;
            byte_cnt  <= cmd_len;
            nack_flag <= 1'b0;
            nack      <= 1'b0;
            busy      <= 1'b1;
            cmd_ready <= 1'b0;
            state     <= START;
          end
        end
        START: if (tick) begin
          if (quarter == 2'd0) begin
            iic_sda_oe <= 1'b1;
            quarter    <= 2'd1;
          end else begin
            iic_scl <= 1'b0;
            shifter <= {SLAVE_ADDR, 1'b0};
            quarter <= '0;
            bit_cnt <= '0;
            state   <= ADDR;
          end
        end
        ADDR, CTRL, DATA: if (tick) begin
          quarter <= quarter + 2'd1;
          case (quarter)
            2'd0: iic_sda_oe <= (bit_cnt == ACK_BIT) ? 1'b0 : ~shifter[7];
            2'd1: iic_scl <= 1'b1;
            2'd2: if (bit_cnt == ACK_BIT) nack_flag <= iic_sda_i;
            default: begin
              iic_scl <= 1'b0;
              if (bit_cnt != ACK_BIT) begin
                bit_cnt <= bit_cnt + 4'd1;
                shifter <= {shifter[6:0], 1'b0};
              end else begin
                bit_cnt <= '0;
                if (nack_flag) begin
                  state <= STOP;
                end else if (state == ADDR) begin
                  shifter <= ctrl_byte;
                  state   <= CTRL;
                end else if (state == CTRL) begin
                  wr_ready <= 1'b1;
                  state    <= DATA;
                end else if (byte_cnt == '0) begin
                  state <= STOP;
                end else begin
                  byte_cnt <= byte_cnt - LEN_W'(1);
                  wr_ready <= 1'b1;
                end
              end
            end
          endcase
        end
        STOP: begin
          if (quarter == 2'd3) begin
            done      <= 1'b1;
            nack      <= nack_flag;
            busy      <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end else if (tick) begin
            quarter <= quarter + 2'd1;
            case (quarter)
              2'd0:    iic_sda_oe <= 1'b1;
              2'd1:    iic_scl    <= 1'b1;
              default: iic_sda_oe <= 1'b0;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_oled_burst_wr.sv
// Scoreboard bench: stimulus queues expected bus bytes/STOP/done, a bus monitor pops and compares.
module tb_iic_oled_burst_wr;

  localparam int         DIV      = 5;
  localparam logic [6:0] ADDR7    = 7'h3C;
  localparam int         TOK_STOP = 256;
  localparam int         TOK_DONE = 512;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       sel = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ctrl = 1'b0;
  logic [7:0] cmd_len = '0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = '0;
  logic       ack_drv = 1'b0;

  always #5 sys_clk = ~sys_clk;

  logic cmd_ready0, wr_ready0, scl0, oe0, busy0, done0, nack0, sda_i0;
  logic cmd_ready1, wr_ready1, scl1, oe1, busy1, done1, nack1, sda_i1;
  logic cmd_valid0, cmd_valid1, wr_valid0, wr_valid1;

  assign cmd_valid0 = cmd_valid & ~sel;
  assign cmd_valid1 = cmd_valid & sel;
  assign wr_valid0  = wr_valid & ~sel;
  assign wr_valid1  = wr_valid & sel;
  assign sda_i0     = ~(oe0 | (ack_drv & ~sel));
  assign sda_i1     = ~(oe1 | (ack_drv & sel));

  logic m_cmd_ready, m_wr_ready, m_scl, m_oe, m_busy, m_done, m_nack;
  assign m_cmd_ready = sel ? cmd_ready1 : cmd_ready0;
  assign m_wr_ready  = sel ? wr_ready1  : wr_ready0;
  assign m_scl       = sel ? scl1       : scl0;
  assign m_oe        = sel ? oe1        : oe0;
  assign m_busy      = sel ? busy1      : busy0;
  assign m_done      = sel ? done1      : done0;
  assign m_nack      = sel ? nack1      : nack0;

  iic_oled_burst_wr #(
    .SYS_CLK(8_000_000), .IIC_CLK(400_000), .SLAVE_ADDR(ADDR7), .LEN_W(8)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid0), .cmd_ready(cmd_ready0), .cmd_ctrl(cmd_ctrl), .cmd_len(cmd_len),
    .wr_valid(wr_valid0), .wr_ready(wr_ready0), .wr_data(wr_data),
    .iic_scl(scl0), .iic_sda_oe(oe0), .iic_sda_i(sda_i0),
    .busy(busy0), .done(done0), .nack(nack0)
  );

  iic_oled_burst_wr #(
    .SYS_CLK(8_000_000), .IIC_CLK(400_000), .SLAVE_ADDR(ADDR7), .LEN_W(1)
  ) dut_len1 (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
    .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_ctrl(cmd_ctrl), .cmd_len(cmd_len[0]),
    .wr_valid(wr_valid1), .wr_ready(wr_ready1), .wr_data(wr_data),
    .iic_scl(scl1), .iic_sda_oe(oe1), .iic_sda_i(sda_i1),
    .busy(busy1), .done(done1), .nack(nack1)
  );

  int n_cmp = 0;
  int n_fail = 0;
  int exp_q[$];
  int len_q[$];
  int cyc = 0;
  int acc_cyc = 0;
  int hs_cnt = 0;
  int rdy_cnt = 0;
  int nack_idx = -1;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic popExpect(input string name, input logic [31:0] act);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected nothing (t=%0t)", name, act, $time);
    end else begin
      checkOutput(name, act, exp_q.pop_front());
    end
  endtask

  // Bus monitor and I2C slave model: decodes START/bytes/STOP, drives ACK, checks done.
  logic       prev_scl = 1'b1, prev_sda = 1'b1, prev_rdy = 1'b0;
  logic       scl_s, sda_s;
  logic [7:0] shreg = '0;
  int         bitcnt = 0;
  int         byte_idx = 0;

  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      ack_drv  = 1'b0;
      bitcnt   = 0;
      byte_idx = 0;
      prev_scl = m_scl;
      prev_sda = ~m_oe;
      prev_rdy = m_wr_ready;
    end else begin
      scl_s = m_scl;
      sda_s = ~(m_oe | ack_drv);
      if (m_wr_ready) rdy_cnt++;
      if (prev_rdy && !m_wr_ready) hs_cnt++;
      if (prev_scl && scl_s && prev_sda && !sda_s) begin
        bitcnt   = 0;
        byte_idx = 0;
      end else if (prev_scl && scl_s && !prev_sda && sda_s) begin
        popExpect("bus_stop", TOK_STOP);
        bitcnt = 0;
      end else if (!prev_scl && scl_s) begin
        if (bitcnt < 8) shreg = {shreg[6:0], sda_s};
        bitcnt++;
        if (bitcnt == 8) popExpect("bus_byte", {24'd0, shreg});
      end else if (prev_scl && !scl_s) begin
        if (bitcnt == 8) begin
          ack_drv = (byte_idx != nack_idx);
        end else if (bitcnt == 9) begin
          ack_drv = 1'b0;
          bitcnt  = 0;
          byte_idx++;
        end
      end
      if (m_done) begin
        popExpect("done_nack", TOK_DONE + int'(m_nack));
        if (len_q.size() > 0) checkOutput("frame_cycles", cyc - acc_cyc, len_q.pop_front());
        else checkOutput("frame_len_queued", len_q.size(), 1);
      end
      prev_scl = scl_s;
      prev_sda = ~(m_oe | ack_drv);
      prev_rdy = m_wr_ready;
    end
  end

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_scl"}, m_scl, 1);
    checkOutput({tag, "_sda_oe"}, m_oe, 0);
    checkOutput({tag, "_cmd_ready"}, m_cmd_ready, 1);
    checkOutput({tag, "_wr_ready"}, m_wr_ready, 0);
    checkOutput({tag, "_busy"}, m_busy, 0);
    checkOutput({tag, "_done"}, m_done, 0);
    checkOutput({tag, "_nack"}, m_nack, 0);
  endtask

  // One frame: queue expectations, accept, feed payload (optionally stalled), wait for done.
  task automatic applyStimulus(input logic ctrl, input int len_m1, input logic [7:0] pay [4],
                               input int nack_at, input int stall_before, input bit pulse_busy);
    logic [7:0] seq [6];
    int n, nbytes, consumed, hs0, rdy0, t;
    logic oe_ref, scl_ref, stable;
    n = len_m1 + 1;
    seq[0] = {ADDR7, 1'b0};
    seq[1] = ctrl ? 8'h00 : 8'h40;
    for (int i = 0; i < 4; i++) seq[i+2] = pay[i];
    nbytes   = (nack_at < 0) ? n + 2 : nack_at + 1;
    consumed = (nack_at < 0) ? n : ((nack_at > 1) ? nack_at - 1 : 0);
    nack_idx = nack_at;
    for (int i = 0; i < nbytes; i++) exp_q.push_back(int'(seq[i]));
    exp_q.push_back(TOK_STOP);
    exp_q.push_back(TOK_DONE + ((nack_at < 0) ? 0 : 1));
    len_q.push_back((2 + 36 * nbytes + 3) * DIV + 1 + ((stall_before >= 0) ? 100 : 0));
    hs0  = hs_cnt;
    rdy0 = rdy_cnt;
    cmd_ctrl  = ctrl;
    cmd_len   = 8'(len_m1);
    cmd_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
    checkOutput("accept_busy", m_busy, 1);
    checkOutput("accept_cmd_ready", m_cmd_ready, 0);
    if (pulse_busy) begin
      repeat (50) @(negedge sys_clk);
      cmd_valid = 1'b1;
      cmd_ctrl  = ~ctrl;
      cmd_len   = 8'd3;
      @(negedge sys_clk);
      cmd_valid = 1'b0;
      cmd_ctrl  = ctrl;
      cmd_len   = 8'(len_m1);
    end
    for (int i = 0; i < consumed; i++) begin
      wr_data  = pay[i];
      wr_valid = (i != stall_before);
      t = 0;
      do begin
        @(negedge sys_clk);
        t++;
      end while (!m_wr_ready && t < 3000);
      checkOutput("wr_ready_wait", m_wr_ready, 1);
      if (i == stall_before) begin
        scl_ref = m_scl;
        oe_ref  = m_oe;
        stable  = 1'b1;
        repeat (100) begin
          @(negedge sys_clk);
          if (m_scl !== 1'b0 || m_oe !== oe_ref || m_wr_ready !== 1'b1) stable = 1'b0;
        end
        checkOutput("stall_scl_low", scl_ref, 0);
        checkOutput("stall_stable", stable, 1);
        wr_valid = 1'b1;
      end
      @(posedge sys_clk);
      #1;
      wr_valid = 1'b0;
    end
    t = 0;
    do begin
      @(negedge sys_clk);
      t++;
    end while (!m_done && t < 6000);
    checkOutput("done_wait", m_done, 1);
    checkOutput("ready_with_done", m_cmd_ready, 1);
    checkOutput("handshakes", hs_cnt - hs0, consumed);
    if (consumed == 0) checkOutput("wr_ready_never", rdy_cnt - rdy0, 0);
  endtask

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic busy_seen;
    repeat (3) @(negedge sys_clk);
    checkResetValues("por");
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    $display("[TB] command byte 0xAE");
    applyStimulus(1'b1, 0, '{8'hAE, 8'h00, 8'h00, 8'h00}, -1, -1, 1'b0);
    repeat (10) @(negedge sys_clk);

    $display("[TB] data burst 0x11 0x22 0x33");
    applyStimulus(1'b0, 2, '{8'h11, 8'h22, 8'h33, 8'h00}, -1, -1, 1'b0);
    repeat (10) @(negedge sys_clk);

    $display("[TB] address NACK");
    applyStimulus(1'b1, 0, '{8'hAE, 8'h00, 8'h00, 8'h00}, 0, -1, 1'b0);
    repeat (10) @(negedge sys_clk);
    checkOutput("nack_hold", m_nack, 1);

    $display("[TB] stretched burst");
    applyStimulus(1'b0, 2, '{8'h5A, 8'hC3, 8'h0F, 8'h00}, -1, 1, 1'b0);
    repeat (10) @(negedge sys_clk);

    $display("[TB] reset during control byte");
    nack_idx = -1;
    exp_q.push_back(int'({ADDR7, 1'b0}));
    cmd_ctrl  = 1'b1;
    cmd_len   = 8'd0;
    cmd_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    cmd_valid = 1'b0;
    repeat (240) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    checkOutput("addr_before_reset", exp_q.size(), 0);
    exp_q.delete();
    repeat (3) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    applyStimulus(1'b1, 0, '{8'h8D, 8'h00, 8'h00, 8'h00}, -1, -1, 1'b0);
    repeat (10) @(negedge sys_clk);

    $display("[TB] cmd_valid pulse while busy");
    applyStimulus(1'b1, 0, '{8'hA5, 8'h00, 8'h00, 8'h00}, -1, -1, 1'b1);
    busy_seen = 1'b0;
    repeat (20) begin
      @(negedge sys_clk);
      if (m_busy !== 1'b0) busy_seen = 1'b1;
    end
    checkOutput("ignored_pulse_idle", busy_seen, 0);

    $display("[TB] back-to-back frames");
    applyStimulus(1'b1, 0, '{8'h14, 8'h00, 8'h00, 8'h00}, -1, -1, 1'b0);
    applyStimulus(1'b0, 0, '{8'hFF, 8'h00, 8'h00, 8'h00}, -1, -1, 1'b0);
    repeat (10) @(negedge sys_clk);

    $display("[TB] LEN_W=1 instance, two bytes");
    sel = 1'b1;
    repeat (2) @(negedge sys_clk);
    applyStimulus(1'b0, 1, '{8'hDE, 8'hAD, 8'h00, 8'h00}, -1, -1, 1'b0);
    repeat (10) @(negedge sys_clk);

    checkOutput("scoreboard_empty", exp_q.size(), 0);
    checkOutput("length_queue_empty", len_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
